spart: RTL and testbench

Special-purpose asynchronous receiver/transmitter (8N1 UART) that sits directly downstream of the bus-master driver on the single-cycle I/O bus. It holds the 16-bit baud divisor, generates a 16x oversampling tick, serializes bytes written to it onto `txd`, and deserializes bytes from `rxd` into a receive buffer. Two status lines, `rda` and `tbr`, tell the master when it may read or write.

---
 rtl/spart.sv | 160 ++++++++++++++++
 tb/tb_spart.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spart.sv
// spart: 8N1 UART with programmable baud divisor on a single-cycle I/O bus
module spart #(
  parameter logic [15:0] DIV_RST = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [15:0] r_div, r_cnt;
  logic [1:0]  r_tx_state, r_rx_state;
  logic [3:0]  r_tx_tick, r_rx_tick;
  logic [2:0]  r_tx_bit, r_rx_bit;
  logic [7:0]  r_tx_buf, r_rx_buf, r_rx_shift;
  logic        r_tbr, r_rda, r_rx_err;
  logic        r_s1, r_s2, r_s3;
  logic        w_wr, w_rd, w_tick, w_wr_tx;
  logic [7:0]  w_rdata;

  assign w_wr    = iocs & ~iorw;
  assign w_rd    = iocs & iorw;
  assign w_tick  = (r_cnt == 16'd0);
  assign w_wr_tx = w_wr & (ioaddr == 2'd0) & r_tbr;
  assign w_rdata = (ioaddr == 2'd0) ? r_rx_buf :
                   (ioaddr == 2'd1) ? {6'b0, r_tbr, r_rda} :
                   (ioaddr == 2'd2) ? r_div[7:0] : r_div[15:8];
  assign databus = w_rd ? w_rdata : 8'bz;
  assign tbr     = r_tbr;
  assign rda     = r_rda;
  assign txd     = (r_tx_state == TX_START) ? 1'b0 :
                   (r_tx_state == TX_DATA)  ? r_tx_buf[r_tx_bit] : 1'b1;

  // Divisor register, written a byte at a time from the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_div <= DIV_RST;
    else if (w_wr && ioaddr == 2'd2) r_div[7:0] <= databus;
    else if (w_wr && ioaddr == 2'd3) r_div[15:8] <= databus;
  end

  // Baud down-counter; a divisor write restarts it with the new value at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= DIV_RST;
    else if (w_wr && ioaddr[1]) r_cnt <= ioaddr[0] ? {databus, r_div[7:0]} : {r_div[15:8], databus};
    else r_cnt <= w_tick ? r_div : r_cnt - 16'd1;
  end

  // Transmitter: latch a byte while idle, then shift start/data/stop at 16 ticks per bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_tick  <= 4'd0;
      r_tx_bit   <= 3'd0;
      r_tx_buf   <= 8'd0;
      r_tbr      <= 1'b1;
    end else begin
      if (w_wr_tx) begin
        r_tx_buf <= databus;
        r_tbr    <= 1'b0;
      end
      case (r_tx_state)
        TX_IDLE: if (!r_tbr && w_tick) begin
          r_tx_state <= TX_START;
          r_tx_tick  <= 4'd0;
          r_tx_bit   <= 3'd0;
        end
        TX_START: if (w_tick) begin
          r_tx_tick <= r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tick) begin
          r_tx_tick <= r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) begin
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) r_tx_state <= TX_STOP;
          end
        end
        default: if (w_tick) begin
          r_tx_tick <= r_tx_tick + 4'd1;
          if (r_tx_tick == 4'd15) begin
            r_tx_state <= TX_IDLE;
            r_tbr      <= 1'b1;
          end
        end
      endcase
    end
  end

  // Two-flop synchronizer for rxd plus a third flop for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {r_s1, r_s2, r_s3} <= 3'b111;
    else {r_s1, r_s2, r_s3} <= {rxd, r_s1, r_s2};
  end

  // Receiver: mid-bit sampling; a completing frame overrides a same-cycle rda clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_tick  <= 4'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
      r_rx_buf   <= 8'd0;
      r_rx_err   <= 1'b0;
      r_rda      <= 1'b0;
    end else begin
      if (w_rd && ioaddr == 2'd0) r_rda <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (r_s3 && !r_s2) begin
          r_rx_state <= RX_START;
          r_rx_tick  <= 4'd0;
        end
        RX_START: if (w_tick) begin
          r_rx_tick <= r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd7) begin
            r_rx_state <= r_s2 ? RX_IDLE : RX_DATA;
            r_rx_tick  <= 4'd0;
            r_rx_bit   <= 3'd0;
          end
        end
        RX_DATA: if (w_tick) begin
          r_rx_tick <= r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd15) begin
            r_rx_shift <= {r_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end
        end
        default: if (r_rx_err) begin
          if (r_s2) begin
            r_rx_err   <= 1'b0;
            r_rx_state <= RX_IDLE;
          end
        end else if (w_tick) begin
          r_rx_tick <= r_rx_tick + 4'd1;
          if (r_rx_tick == 4'd15) begin
            if (r_s2) begin
              r_rx_buf   <= r_rx_shift;
              r_rda      <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else r_rx_err <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spart.sv
// tb_spart: directed self-checking bench for the spart UART
module tb_spart;
  logic       clk = 0, rst = 1, iocs = 0, iorw = 0, rxd_drv = 1, loopb = 0, drv_en = 0;
  logic [1:0] ioaddr = 0;
  logic [7:0] drv = 0, rd;
  wire  [7:0] databus;
  wire        rda, tbr, txd, rxd;
  int         checks = 0, failures = 0;
  bit         ok;

  assign databus = drv_en ? drv : 8'bz;
  assign rxd = loopb ? txd : rxd_drv;

  spart #(.DIV_RST(16'd325)) dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  function automatic logic fbit(input logic [7:0] b, input int i);
    fbit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
  endfunction

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 0; ioaddr = a; drv = d; drv_en = 1;
    @(posedge clk);
    #1 iocs = 0; drv_en = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = a;
    #1 d = databus;
    @(posedge clk);
    #1 iocs = 0; iorw = 0;
  endtask

  task automatic wait_fall(output bit f);
    f = 0;
    for (int i = 0; i < 3000 && !f; i++) begin
      @(negedge clk);
      if (txd === 1'b0) f = 1;
    end
  endtask

  task automatic wait_tbr(output bit f);
    f = 0;
    for (int i = 0; i < 3000 && !f; i++) begin
      @(negedge clk);
      if (tbr === 1'b1) f = 1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd_drv = (i == 9) ? stop : fbit(b, i);
      repeat (63) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
    checks++; if (tbr !== 1'b1) begin failures++; $display("FAIL reset_tbr got=%b exp=1", tbr); end
    checks++; if (rda !== 1'b0) begin failures++; $display("FAIL reset_rda got=%b exp=0", rda); end
    @(negedge clk);
    rst = 0;
    bus_rd(2'd2, rd);
    checks++; if (rd !== 8'h45) begin failures++; $display("FAIL reset_div_lo got=%h exp=45", rd); end
    bus_rd(2'd3, rd);
    checks++; if (rd !== 8'h01) begin failures++; $display("FAIL reset_div_hi got=%h exp=01", rd); end
    bus_rd(2'd1, rd);
    checks++; if (rd !== 8'h02) begin failures++; $display("FAIL reset_status got=%h exp=02", rd); end
  endtask

  task automatic test_tx_55;
    logic e;
    bus_wr(2'd2, 8'h03);
    bus_wr(2'd3, 8'h00);
    bus_rd(2'd2, rd);
    checks++; if (rd !== 8'h03) begin failures++; $display("FAIL div_write got=%h exp=03", rd); end
    bus_wr(2'd0, 8'h55);
    checks++; if (tbr !== 1'b0) begin failures++; $display("FAIL tx_tbr_low got=%b exp=0", tbr); end
    wait_fall(ok);
    checks++; if (!ok) begin failures++; $display("FAIL tx_start_timeout got=none exp=fall"); end
    for (int k = 0; k <= 640; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 640 && (k % 64 == 0 || k % 64 == 63)) begin
        e = fbit(8'h55, k / 64);
        checks++; if (txd !== e) begin failures++; $display("FAIL tx_bit k=%0d got=%b exp=%b", k, txd, e); end
      end
      if (k == 639) begin
        checks++; if (tbr !== 1'b0) begin failures++; $display("FAIL tx_tbr_639 got=%b exp=0", tbr); end
      end
      if (k == 640) begin
        checks++; if (tbr !== 1'b1) begin failures++; $display("FAIL tx_tbr_640 got=%b exp=1", tbr); end
      end
    end
  endtask

  task automatic test_loopback;
    loopb = 1;
    bus_wr(2'd0, 8'hA5);
    wait_tbr(ok);
    checks++; if (!ok) begin failures++; $display("FAIL loop_tbr_timeout got=0 exp=1"); end
    bus_rd(2'd1, rd);
    checks++; if (rd !== 8'h03) begin failures++; $display("FAIL loop_status got=%h exp=03", rd); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 8'hA5) begin failures++; $display("FAIL loop_data got=%h exp=a5", rd); end
    checks++; if (rda !== 1'b0) begin failures++; $display("FAIL loop_rda_clear got=%b exp=0", rda); end
  endtask

  task automatic test_busy_write;
    bus_wr(2'd0, 8'h3C);
    repeat (100) @(negedge clk);
    checks++; if (tbr !== 1'b0) begin failures++; $display("FAIL busy_tbr got=%b exp=0", tbr); end
    bus_wr(2'd0, 8'h00);
    wait_tbr(ok);
    checks++; if (!ok) begin failures++; $display("FAIL busy_tbr_timeout got=0 exp=1"); end
    repeat (4) @(negedge clk);
    bus_rd(2'd0, rd);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL busy_data got=%h exp=3c", rd); end
  endtask

  task automatic test_rx_errors;
    loopb = 0;
    rxd_drv = 1;
    repeat (10) @(negedge clk);
    rxd_drv = 0;
    repeat (20) @(negedge clk);
    rxd_drv = 1;
    repeat (200) @(negedge clk);
    checks++; if (rda !== 1'b0) begin failures++; $display("FAIL glitch_rda got=%b exp=0", rda); end
    send_frame(8'h77, 1'b0);
    repeat (200) @(negedge clk);
    checks++; if (rda !== 1'b0) begin failures++; $display("FAIL frame_err_rda got=%b exp=0", rda); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL frame_err_buf got=%h exp=3c", rd); end
  endtask

  task automatic test_simultaneous;
    bit found;
    logic [7:0] snap;
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    checks++; if (rda !== 1'b1) begin failures++; $display("FAIL rx_81_rda got=%b exp=1", rda); end
    @(negedge clk);
    iocs = 1; iorw = 1; ioaddr = 2'd0;
    found = 0;
    snap = 8'h00;
    fork
      send_frame(8'h5A, 1'b1);
      for (int i = 0; i < 1500 && !found; i++) begin
        @(negedge clk);
        if (rda === 1'b1) begin
          found = 1;
          snap = databus;
          iocs = 0; iorw = 0;
        end
      end
    join
    iocs = 0; iorw = 0;
    checks++; if (!found) begin failures++; $display("FAIL simul_rda_timeout got=0 exp=1"); end
    checks++; if (snap !== 8'h5A) begin failures++; $display("FAIL simul_buf got=%h exp=5a", snap); end
    checks++; if (rda !== 1'b1) begin failures++; $display("FAIL simul_rda_held got=%b exp=1", rda); end
    bus_rd(2'd0, rd);
    checks++; if (rd !== 8'h5A) begin failures++; $display("FAIL simul_read got=%h exp=5a", rd); end
    checks++; if (rda !== 1'b0) begin failures++; $display("FAIL simul_rda_clear got=%b exp=0", rda); end
  endtask

  task automatic test_reset_mid;
    bus_wr(2'd0, 8'h0F);
    wait_fall(ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_start_timeout got=none exp=fall"); end
    repeat (352) @(negedge clk);
    checks++; if (txd !== 1'b0) begin failures++; $display("FAIL mid_bit4 got=%b exp=0", txd); end
    rst = 1;
    #1;
    checks++; if (txd !== 1'b1) begin failures++; $display("FAIL mid_rst_txd got=%b exp=1", txd); end
    checks++; if (tbr !== 1'b1) begin failures++; $display("FAIL mid_rst_tbr got=%b exp=1", tbr); end
    @(negedge clk);
    rst = 0;
    bus_rd(2'd2, rd);
    checks++; if (rd !== 8'h45) begin failures++; $display("FAIL mid_rst_div got=%h exp=45", rd); end
  endtask

  initial begin
    test_reset;
    test_tx_55;
    test_loopback;
    test_busy_write;
    test_rx_errors;
    test_simultaneous;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
